// File: rtl/pulpito_mailbox_pkg.sv
// Shared definitions for the pulpito mailbox: register offsets (word index,
// i.e. address bits [3:2]), AXI response codes and the write/read FSM states.
package pulpito_mailbox_pkg;

    localparam logic [1:0] MBX_TXDATA = 2'd0;
    localparam logic [1:0] MBX_RXDATA = 2'd1;
    localparam logic [1:0] MBX_STATUS = 2'd2;
    localparam logic [1:0] MBX_IRQEN  = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_t;

endpackage

// File: rtl/pulpito_mailbox_fifo.sv
// Synchronous single-clock FIFO used for both mailbox directions.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (empties the FIFO)
//   push, data_in   write request and word; ignored while full
//   pop             read request; ignored while empty
//   data_out        head word, combinational from the storage array
//   full, empty     status derived from the registered count
//   count           number of stored words, 0..DEPTH
module pulpito_mailbox_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         data_in,
    output logic [WIDTH-1:0]         data_out,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Gating on pre-cycle full/empty: a pop cannot make room for a push in the
    // same cycle, and a push into an empty FIFO cannot be popped in that cycle.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign data_out = mem[rd_ptr];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/pulpito_mailbox.sv
// AXI4-Lite slave mailbox between the RISC-V core (AXI side) and the host
// stream side. p2h: core writes TXDATA, host drains. h2p: host fills, core
// reads RXDATA. STATUS and IRQ_EN registers plus a registered level IRQ.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   aw*/w*/b*                      AXI-Lite write address/data/response
//   ar*/r*                         AXI-Lite read address/data
//   p2h_data_o/valid_o/ready_i     host drain side of the p2h FIFO
//   h2p_data_i/valid_i/ready_o     host fill side of the h2p FIFO
//   irq_o                          IRQ_EN[0] && h2p not empty, registered
//
// Write FSM
//   state  | meaning
//   W_IDLE | collecting AW and W (any order); action runs when both are held
//   W_RESP | bvalid high with the registered bresp, waiting for bready
// Read FSM
//   state  | meaning
//   R_IDLE | arready high; on AR the response is computed and registered
//   R_RESP | rvalid high, rdata/rresp held until rready
module pulpito_mailbox
    import pulpito_mailbox_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [DATA_WIDTH-1:0]   p2h_data_o,
    output logic                    p2h_valid_o,
    input  logic                    p2h_ready_i,
    input  logic [DATA_WIDTH-1:0]   h2p_data_i,
    input  logic                    h2p_valid_i,
    output logic                    h2p_ready_o,
    output logic                    irq_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    wr_state_t wstate, wstate_nx;
    rd_state_t rstate, rstate_nx;

    // Held low through reset and the first edge after it, so every ready
    // output is 0 while rst is asserted.
    logic active;

    logic                  aw_held, w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  wstrb0_q;
    logic                  irq_en;

    logic                  aw_hs, w_hs, ar_hs;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_strb0;
    logic                  w_fire;
    logic                  irq_en_wr;
    logic [1:0]            bresp_nx, rresp_nx;
    logic [DATA_WIDTH-1:0] rdata_nx;
    logic [31:0]           status;

    logic                  p2h_push, p2h_pop, p2h_full, p2h_empty;
    logic                  h2p_push, h2p_pop, h2p_full, h2p_empty;
    logic [DATA_WIDTH-1:0] h2p_head;
    logic [CW-1:0]         p2h_count, h2p_count;

    assign awready = active && (wstate == W_IDLE) && !aw_held;
    assign wready  = active && (wstate == W_IDLE) && !w_held;
    assign arready = active && (rstate == R_IDLE);
    assign bvalid  = (wstate == W_RESP);
    assign rvalid  = (rstate == R_RESP);

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign ar_hs = arvalid && arready;

    // Latched copy wins; otherwise the beat being accepted this cycle.
    assign wr_addr  = aw_held ? aw_addr_q : awaddr;
    assign wr_data  = w_held  ? wdata_q   : wdata;
    assign wr_strb0 = w_held  ? wstrb0_q  : wstrb[0];

    assign p2h_valid_o = !p2h_empty;
    assign p2h_pop     = p2h_ready_i && p2h_valid_o;
    assign h2p_ready_o = active && !h2p_full;
    assign h2p_push    = h2p_valid_i && h2p_ready_o;

    always_comb begin
        status       = '0;
        status[0]    = p2h_full;
        status[1]    = p2h_empty;
        status[2]    = h2p_full;
        status[3]    = h2p_empty;
        status[15:8] = 8'(h2p_count);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate <= W_IDLE;
            rstate <= R_IDLE;
        end else begin
            wstate <= wstate_nx;
            rstate <= rstate_nx;
        end
    end

    always_comb begin
        wstate_nx = wstate;
        w_fire    = 1'b0;
        p2h_push  = 1'b0;
        irq_en_wr = 1'b0;
        bresp_nx  = bresp;
        case (wstate)
            W_IDLE: begin
                if ((aw_held || aw_hs) && (w_held || w_hs)) begin
                    w_fire    = 1'b1;
                    wstate_nx = W_RESP;
                    if (|wr_addr[ADDR_WIDTH-1:4]) begin
                        bresp_nx = RESP_DECERR;
                    end else begin
                        bresp_nx = RESP_OKAY;
                        case (wr_addr[3:2])
                            MBX_TXDATA: begin
                                if (p2h_full) bresp_nx = RESP_SLVERR;
                                else          p2h_push = 1'b1;
                            end
                            MBX_IRQEN: irq_en_wr = wr_strb0;
                            default: ;
                        endcase
                    end
                end
            end
            W_RESP: begin
                if (bready) wstate_nx = W_IDLE;
            end
            default: wstate_nx = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_nx = rstate;
        h2p_pop   = 1'b0;
        rdata_nx  = rdata;
        rresp_nx  = rresp;
        case (rstate)
            R_IDLE: begin
                if (ar_hs) begin
                    rstate_nx = R_RESP;
                    rdata_nx  = '0;
                    if (|araddr[ADDR_WIDTH-1:4]) begin
                        rresp_nx = RESP_DECERR;
                    end else begin
                        rresp_nx = RESP_OKAY;
                        case (araddr[3:2])
                            MBX_RXDATA: begin
                                if (h2p_empty) begin
                                    rresp_nx = RESP_SLVERR;
                                end else begin
                                    rdata_nx = h2p_head;
                                    h2p_pop  = 1'b1;
                                end
                            end
                            MBX_STATUS: rdata_nx = status;
                            MBX_IRQEN:  rdata_nx = {31'b0, irq_en};
                            default: ;
                        endcase
                    end
                end
            end
            R_RESP: begin
                if (rready) rstate_nx = R_IDLE;
            end
            default: rstate_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active    <= 1'b0;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            wdata_q   <= '0;
            wstrb0_q  <= 1'b0;
            bresp     <= RESP_OKAY;
            rresp     <= RESP_OKAY;
            rdata     <= '0;
            irq_en    <= 1'b0;
            irq_o     <= 1'b0;
        end else begin
            active <= 1'b1;
            if (w_fire) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= awaddr;
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    wdata_q  <= wdata;
                    wstrb0_q <= wstrb[0];
                end
            end
            bresp <= bresp_nx;
            rresp <= rresp_nx;
            rdata <= rdata_nx;
            if (irq_en_wr) irq_en <= wr_data[0];
            irq_o <= irq_en && !h2p_empty;
        end
    end

    pulpito_mailbox_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_p2h (
        .clk      (clk),
        .rst      (rst),
        .push     (p2h_push),
        .pop      (p2h_pop),
        .data_in  (wr_data),
        .data_out (p2h_data_o),
        .full     (p2h_full),
        .empty    (p2h_empty),
        .count    (p2h_count)
    );

    pulpito_mailbox_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_h2p (
        .clk      (clk),
        .rst      (rst),
        .push     (h2p_push),
        .pop      (h2p_pop),
        .data_in  (h2p_data_i),
        .data_out (h2p_head),
        .full     (h2p_full),
        .empty    (h2p_empty),
        .count    (h2p_count)
    );

    // Bits that are deliberately not decoded.
    logic unused_bits;
    assign unused_bits = ^{p2h_count, wr_addr[1:0], araddr[1:0], wstrb[DATA_WIDTH/8-1:1]};

endmodule
